// File: rtl/lif_sweep_scheduler.sv
// Time-multiplexed leaky integrate-and-fire controller: one shared update datapath
// sweeps N_NEURONS virtual neurons per tick and emits spikes over valid/ready.
module lif_sweep_scheduler #(
    parameter int unsigned N_NEURONS  = 8,
    parameter int unsigned VW         = 16,
    parameter int unsigned IW         = 8,
    parameter int unsigned VTH        = 50,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int unsigned REFRAC     = 2,
    localparam int unsigned AW        = $clog2(N_NEURONS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    output logic [AW-1:0] i_addr,
    input  logic [IW-1:0] i_data,
    output logic          spike_valid,
    output logic [AW-1:0] spike_id,
    input  logic          spike_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] cur_idx,
    output logic          overrun,
    input  logic [AW-1:0] dbg_addr,
    output logic [VW-1:0] dbg_vmem
);
    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

    localparam logic [VW-1:0] VTH_V    = VW'(VTH);
    localparam logic [3:0]    REFRAC_V = 4'(REFRAC);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

    state_t        state;
    logic [VW-1:0] vmem [N_NEURONS];
    logic [3:0]    refc [N_NEURONS];

    logic [VW-1:0] v_cur;
    logic [3:0]    r_cur;
    logic [VW:0]   full;
    logic [VW-1:0] sum;
    logic          stall, proc, fire, nxt_sv;

    assign i_addr   = cur_idx;
    assign dbg_vmem = vmem[dbg_addr];

    always_comb begin
        v_cur  = vmem[cur_idx];
        r_cur  = refc[cur_idx];
        full   = {1'b0, v_cur} - {1'b0, v_cur >> LEAK_SHIFT} + {{(VW + 1 - IW){1'b0}}, i_data};
        sum    = full[VW] ? '1 : full[VW-1:0];
        fire   = (r_cur == 4'd0) && (sum >= VTH_V);
        stall  = spike_valid && !spike_ready;
        proc   = (state == S_UPDATE) && !stall;
        // A new spike on a processing cycle overrides the clear from a completed handshake.
        nxt_sv = (proc && fire) ? 1'b1 : (spike_ready ? 1'b0 : spike_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cur_idx     <= '0;
            spike_valid <= 1'b0;
            spike_id    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                vmem[i] <= '0;
                refc[i] <= '0;
            end
        end else begin
            done        <= 1'b0;
            spike_valid <= nxt_sv;
            if (proc && fire)
                spike_id <= cur_idx;
            if (tick && state != S_IDLE)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        state   <= S_UPDATE;
                        cur_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (proc) begin
                        if (r_cur != 4'd0) begin
                            vmem[cur_idx] <= '0;
                            refc[cur_idx] <= r_cur - 4'd1;
                        end else if (fire) begin
                            vmem[cur_idx] <= '0;
                            refc[cur_idx] <= REFRAC_V;
                        end else begin
                            vmem[cur_idx] <= sum;
                        end
                        if (cur_idx == LAST_IDX) begin
                            state <= S_DONE;
                            done  <= !nxt_sv;
                        end else begin
                            cur_idx <= cur_idx + AW'(1);
                        end
                    end
                end
                S_DONE: begin
                    // done is registered one cycle ahead so it coincides with spike_valid low.
                    if (!spike_valid) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        done <= !nxt_sv;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// Self-checking bench for lif_sweep_scheduler: a 16-bit and an 8-bit saturating instance,
// checked against an arithmetic per-sweep model.
`timescale 1ns/1ps
module tb_lif_sweep_scheduler;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       tick0 = 1'b0, sv0, sr0 = 1'b1, busy0, done0, ovr0;
    logic [1:0] ia0, sid0, cidx0, dba0 = '0;
    logic [7:0] id0;
    logic [15:0] dbv0;
    logic [7:0] curr0 [N];

    logic       tick1 = 1'b0, sv1, sr1 = 1'b1, busy1, done1, ovr1;
    logic [1:0] ia1, sid1, cidx1, dba1 = '0;
    logic [7:0] id1;
    logic [7:0] dbv1;
    logic [7:0] curr1 [N];

    assign id0 = curr0[ia0];
    assign id1 = curr1[ia1];

    lif_sweep_scheduler #(.N_NEURONS(4), .VW(16), .IW(8), .VTH(50), .LEAK_SHIFT(3), .REFRAC(2)) dut0 (
        .clk(clk), .reset(reset), .tick(tick0), .i_addr(ia0), .i_data(id0),
        .spike_valid(sv0), .spike_id(sid0), .spike_ready(sr0), .busy(busy0), .done(done0),
        .cur_idx(cidx0), .overrun(ovr0), .dbg_addr(dba0), .dbg_vmem(dbv0));

    lif_sweep_scheduler #(.N_NEURONS(4), .VW(8), .IW(8), .VTH(255), .LEAK_SHIFT(3), .REFRAC(2)) dut1 (
        .clk(clk), .reset(reset), .tick(tick1), .i_addr(ia1), .i_data(id1),
        .spike_valid(sv1), .spike_id(sid1), .spike_ready(sr1), .busy(busy1), .done(done1),
        .cur_idx(cidx1), .overrun(ovr1), .dbg_addr(dba1), .dbg_vmem(dbv1));

    int errors = 0;
    int checks = 0;
    int mv [2][N];
    int mr [2][N];
    int exp0[$], exp1[$], acc0[$], acc1[$];
    int dcnt0 = 0, dcnt1 = 0;

    always @(posedge clk) begin
        if (!reset) begin
            if (sv0 && sr0) acc0.push_back(int'(sid0));
            if (sv1 && sr1) acc1.push_back(int'(sid1));
            if (done0) dcnt0++;
            if (done1) dcnt1++;
        end
    end

    // One timestep for every neuron, straight from the update rules.
    function automatic void model_sweep(input int d, input int cur[N]);
        int vmax = (d == 0) ? 65535 : 255;
        int vth  = (d == 0) ? 50 : 255;
        int s;
        for (int k = 0; k < N; k++) begin
            if (mr[d][k] != 0) begin
                mv[d][k] = 0;
                mr[d][k] = mr[d][k] - 1;
            end else begin
                s = mv[d][k] - mv[d][k] / 8 + cur[k];
                if (s > vmax) s = vmax;
                if (s >= vth) begin
                    mv[d][k] = 0;
                    mr[d][k] = 2;
                    if (d == 0) exp0.push_back(k); else exp1.push_back(k);
                end else begin
                    mv[d][k] = s;
                end
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick0 = 1'b0; tick1 = 1'b0; sr0 = 1'b1; sr1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < N; k++) begin mv[d][k] = 0; mr[d][k] = 0; end
        exp0.delete(); exp1.delete(); acc0.delete(); acc1.delete();
        dcnt0 = 0; dcnt1 = 0;
    endtask

    task automatic run_sweep0(input int rdy_pct, output int cyc, output bit tmo);
        tick0 = 1'b1;
        step();
        tick0 = 1'b0;
        cyc = 1;
        while (!done0 && cyc < 200) begin
            sr0 = ($urandom_range(99) < rdy_pct);
            step();
            cyc++;
        end
        tmo = !done0;
        sr0 = 1'b1;
        step();
    endtask

    task automatic run_sweep1(output int cyc, output bit tmo);
        tick1 = 1'b1;
        step();
        tick1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 200) begin
            step();
            cyc++;
        end
        tmo = !done1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({sv0, sid0, busy0, done0, cidx0, ovr0} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs0: got %b expected 00000000", {sv0, sid0, busy0, done0, cidx0, ovr0});
        end
        checks++;
        if ({sv1, sid1, busy1, done1, cidx1, ovr1} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs1: got %b expected 00000000", {sv1, sid1, busy1, done1, cidx1, ovr1});
        end
        for (int i = 0; i < N; i++) begin
            dba0 = 2'(i);
            #1;
            checks++;
            if (dbv0 !== 16'd0) begin
                errors++;
                $display("FAIL reset_vmem[%0d]: got %0d expected 0", i, dbv0);
            end
        end
    endtask

    task automatic test_timing();
        int c[N] = '{0, 0, 0, 0};
        for (int i = 0; i < N; i++) curr0[i] = 8'(c[i]);
        tick0 = 1'b1;
        step();
        tick0 = 1'b0;
        for (int e = 1; e <= N + 2; e++) begin
            checks++;
            if (busy0 !== (e <= N + 1)) begin
                errors++;
                $display("FAIL timing_busy@%0d: got %b expected %b", e, busy0, (e <= N + 1));
            end
            checks++;
            if (done0 !== (e == N + 1)) begin
                errors++;
                $display("FAIL timing_done@%0d: got %b expected %b", e, done0, (e == N + 1));
            end
            checks++;
            if (sv0 !== 1'b0) begin
                errors++;
                $display("FAIL timing_spike@%0d: got %b expected 0", e, sv0);
            end
            if (e <= N) begin
                checks++;
                if (int'(cidx0) != e - 1) begin
                    errors++;
                    $display("FAIL timing_cur_idx@%0d: got %0d expected %0d", e, cidx0, e - 1);
                end
            end
            step();
        end
        model_sweep(0, c);
    endtask

    task automatic test_spec_sequence();
        int c[N] = '{10, 0, 0, 0};
        int tbl[10] = '{10, 19, 27, 34, 40, 45, 0, 0, 0, 10};
        int cyc;
        bit tmo;
        do_reset();
        for (int i = 0; i < N; i++) curr0[i] = 8'(c[i]);
        dba0 = 2'd0;
        for (int t = 0; t < 10; t++) begin
            run_sweep0(100, cyc, tmo);
            model_sweep(0, c);
            checks++;
            if (tmo || cyc != N + 1) begin
                errors++;
                $display("FAIL seq_done_latency tick%0d: got %0d cycles (timeout=%0d) expected %0d", t + 1, cyc, tmo, N + 1);
            end
            checks++;
            if (int'(dbv0) != tbl[t]) begin
                errors++;
                $display("FAIL seq_vmem0 tick%0d: got %0d expected %0d", t + 1, dbv0, tbl[t]);
            end
            checks++;
            if (acc0.size() != ((t >= 6) ? 1 : 0)) begin
                errors++;
                $display("FAIL seq_spike_count tick%0d: got %0d expected %0d", t + 1, acc0.size(), (t >= 6) ? 1 : 0);
            end
        end
        checks++;
        if (acc0.size() != 1 || acc0[0] != 0) begin
            errors++;
            $display("FAIL seq_spike_id: got size %0d first %0d expected size 1 id 0", acc0.size(), (acc0.size() > 0) ? acc0[0] : -1);
        end
    endtask

    task automatic test_random();
        int c[N];
        int cyc, d0;
        bit tmo;
        for (int s = 0; s < 12; s++) begin
            for (int i = 0; i < N; i++) begin
                c[i] = $urandom_range(0, 40);
                curr0[i] = 8'(c[i]);
            end
            exp0.delete(); acc0.delete();
            d0 = dcnt0;
            run_sweep0(60, cyc, tmo);
            model_sweep(0, c);
            checks++;
            if (tmo || dcnt0 - d0 != 1) begin
                errors++;
                $display("FAIL rand_done sweep%0d: got %0d pulses (timeout=%0d) expected 1", s, dcnt0 - d0, tmo);
            end
            checks++;
            if (acc0.size() != exp0.size()) begin
                errors++;
                $display("FAIL rand_spike_count sweep%0d: got %0d expected %0d", s, acc0.size(), exp0.size());
            end
            for (int i = 0; i < exp0.size() && i < acc0.size(); i++) begin
                checks++;
                if (acc0[i] != exp0[i]) begin
                    errors++;
                    $display("FAIL rand_spike_id sweep%0d[%0d]: got %0d expected %0d", s, i, acc0[i], exp0[i]);
                end
            end
            for (int i = 0; i < N; i++) begin
                dba0 = 2'(i);
                #1;
                checks++;
                if (int'(dbv0) != mv[0][i]) begin
                    errors++;
                    $display("FAIL rand_vmem sweep%0d n%0d: got %0d expected %0d", s, i, dbv0, mv[0][i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        int c1[N] = '{0, 45, 45, 0};
        int c2[N] = '{0, 10, 10, 0};
        int cyc;
        bit tmo;
        do_reset();
        for (int i = 0; i < N; i++) curr0[i] = 8'(c1[i]);
        run_sweep0(100, cyc, tmo);
        model_sweep(0, c1);
        for (int i = 0; i < N; i++) curr0[i] = 8'(c2[i]);
        exp0.delete(); acc0.delete();
        model_sweep(0, c2);
        dba0 = 2'd2;
        tick0 = 1'b1;
        step();
        tick0 = 1'b0;
        step();
        step();
        checks++;
        if ({sv0, sid0, cidx0} !== {1'b1, 2'd1, 2'd2}) begin
            errors++;
            $display("FAIL stall_first_spike: got valid=%b id=%0d idx=%0d expected valid=1 id=1 idx=2", sv0, sid0, cidx0);
        end
        sr0 = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            checks++;
            if ({sv0, sid0, cidx0} !== {1'b1, 2'd1, 2'd2} || dbv0 !== 16'd45) begin
                errors++;
                $display("FAIL stall_hold@%0d: got valid=%b id=%0d idx=%0d vmem2=%0d expected 1/1/2/45", s, sv0, sid0, cidx0, dbv0);
            end
        end
        sr0 = 1'b1;
        step();
        checks++;
        if ({sv0, sid0} !== {1'b1, 2'd2} || dbv0 !== 16'd0) begin
            errors++;
            $display("FAIL stall_second_spike: got valid=%b id=%0d vmem2=%0d expected 1/2/0", sv0, sid0, dbv0);
        end
        step();
        checks++;
        if (done0 !== 1'b1) begin
            errors++;
            $display("FAIL stall_done_delay: got done=%b expected 1", done0);
        end
        step();
        checks++;
        if (acc0.size() != 2 || acc0[0] != exp0[0] || acc0[1] != exp0[1]) begin
            errors++;
            $display("FAIL stall_spike_order: got %0d events expected %0d", acc0.size(), exp0.size());
        end
    endtask

    task automatic test_overrun();
        int c[N] = '{0, 0, 0, 0};
        int d0, e;
        do_reset();
        for (int i = 0; i < N; i++) curr0[i] = 8'(c[i]);
        d0 = dcnt0;
        tick0 = 1'b1;
        step();
        step();
        tick0 = 1'b0;
        checks++;
        if (ovr0 !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", ovr0);
        end
        e = 2;
        while (!done0 && e < 50) begin
            step();
            e++;
        end
        checks++;
        if (e != N + 1) begin
            errors++;
            $display("FAIL overrun_done_edge: got %0d expected %0d", e, N + 1);
        end
        for (int s = 0; s < 6; s++) step();
        checks++;
        if (busy0 !== 1'b0 || ovr0 !== 1'b1 || dcnt0 - d0 != 1) begin
            errors++;
            $display("FAIL overrun_no_extra_sweep: got busy=%b overrun=%b pulses=%0d expected 0/1/1", busy0, ovr0, dcnt0 - d0);
        end
        model_sweep(0, c);
    endtask

    task automatic test_reset_mid();
        int d0;
        curr0[0] = 8'd30; curr0[1] = 8'd20; curr0[2] = 8'd40; curr0[3] = 8'd10;
        tick0 = 1'b1;
        step();
        tick0 = 1'b0;
        step();
        step();
        checks++;
        if (cidx0 !== 2'd2 || dbv0 === 16'd0) begin
            dba0 = 2'd0;
        end
        if (cidx0 !== 2'd2) begin
            errors++;
            $display("FAIL midreset_index: got %0d expected 2", cidx0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({sv0, sid0, busy0, done0, cidx0, ovr0} !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 00000000", {sv0, sid0, busy0, done0, cidx0, ovr0});
        end
        for (int i = 0; i < N; i++) begin
            dba0 = 2'(i);
            #1;
            checks++;
            if (dbv0 !== 16'd0) begin
                errors++;
                $display("FAIL midreset_vmem[%0d]: got %0d expected 0", i, dbv0);
            end
        end
        d0 = dcnt0;
        for (int s = 0; s < 8; s++) step();
        checks++;
        if (dcnt0 != d0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_done: got pulses=%0d busy=%b expected 0/0", dcnt0 - d0, busy0);
        end
        for (int k = 0; k < N; k++) begin mv[0][k] = 0; mr[0][k] = 0; end
    endtask

    task automatic test_saturation();
        int c[N] = '{255, 200, 100, 30};
        int cyc;
        bit tmo;
        do_reset();
        for (int i = 0; i < N; i++) curr1[i] = 8'(c[i]);
        for (int t = 0; t < 6; t++) begin
            exp1.delete(); acc1.delete();
            run_sweep1(cyc, tmo);
            model_sweep(1, c);
            checks++;
            if (tmo || acc1.size() != exp1.size()) begin
                errors++;
                $display("FAIL sat_spike_count tick%0d: got %0d (timeout=%0d) expected %0d", t + 1, acc1.size(), tmo, exp1.size());
            end
            for (int i = 0; i < N; i++) begin
                dba1 = 2'(i);
                #1;
                checks++;
                if (int'(dbv1) != mv[1][i]) begin
                    errors++;
                    $display("FAIL sat_vmem tick%0d n%0d: got %0d expected %0d", t + 1, i, dbv1, mv[1][i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin curr0[i] = '0; curr1[i] = '0; end
        test_reset();
        test_timing();
        test_spec_sequence();
        test_random();
        test_back_to_back_stall();
        test_overrun();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lif_sweep_scheduler.md
# lif_sweep_scheduler

Time-multiplexed controller that shares one leaky integrate-and-fire update datapath across `N_NEURONS` virtual neurons. On each `tick` it sweeps every neuron in index order, one neuron per cycle, and fetches its input current from an external current register file. It writes back membrane state, manages refractory periods, and emits spike events over a valid/ready handshake. It sits between the stimulus/current source and the downstream spike router, replacing one LIF instance per neuron.

## Interface
Parameters:
- `N_NEURONS`, default 8: number of virtual neurons (≥2); index width `AW = $clog2(N_NEURONS)`.
- `VW`, default 16: membrane potential width (unsigned).
- `IW`, default 8: input current width (unsigned, IW ≤ VW).
- `VTH`, default 50: firing threshold, VW bits.
- `LEAK_SHIFT`, default 3: leak term is `V >> LEAK_SHIFT`.
- `REFRAC`, default 2: refractory ticks after a spike (0 disables), 4-bit counter per neuron.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `tick`  in  1: start one timestep sweep; sampled only in IDLE.
- `i_addr`  out  AW: neuron index whose current is requested, equals `cur_idx`.
- `i_data`  in  IW: current for `i_addr`, combinational same-cycle return from external file.
- `spike_valid`  out  1: spike event pending.
- `spike_id`  out  AW: index of spiking neuron.
- `spike_ready`  in  1: downstream accepts event when high with `spike_valid`.
- `busy`  out  1: high in UPDATE and DONE.
- `done`  out  1: one-cycle pulse at sweep end.
- `cur_idx`  out  AW: neuron being processed.
- `overrun`  out  1: sticky; set when `tick` arrives while not IDLE.
- `dbg_addr`  in  AW / `dbg_vmem`  out  VW: combinational read of stored membrane potential.

## Operation
- State storage: per-neuron `vmem[VW]` and `refc[4]`, all zero on reset.
- FSM states are IDLE, UPDATE and DONE.
  - IDLE → UPDATE on `tick`, with `cur_idx`←0.
  - UPDATE processes `cur_idx` each non-stalled cycle. After processing `N_NEURONS-1`, it goes to DONE.
  - DONE waits until `spike_valid` is 0, then pulses `done` for one cycle and returns to IDLE.
- Stall: UPDATE does not process (no writeback, no index advance) in any cycle where `spike_valid && !spike_ready`.
- Per-neuron update when processed:
  - If `refc != 0`: `vmem`←0, `refc`←`refc-1`, no spike.
  - Otherwise: `sum = vmem - (vmem >> LEAK_SHIFT) + i_data`, computed at VW+1 bits, saturated to `2^VW-1`.
    - If `sum >= VTH`: `vmem`←0, `refc`←`REFRAC`, spike.
    - Else `vmem`←`sum`.
- Spike event: on the processing cycle, `spike_valid`←1 and `spike_id`←`cur_idx` (registered). `spike_valid` clears on a cycle where `spike_ready` is 1, unless the same cycle processes another spiking neuron, in which case it stays 1 with the new id.
- `overrun` sets on `tick` in UPDATE or DONE. That tick is otherwise ignored. Only reset clears `overrun`.
- Reset mid-sweep aborts the sweep. All state, counters and outputs go to zero and the FSM goes to IDLE. No `done` is produced.

## Timing
- Reset values: `spike_valid`=0, `spike_id`=0, `busy`=0, `done`=0, `cur_idx`=0, `overrun`=0, all `vmem`/`refc`=0.
- Tick sampled in cycle T. UPDATE begins at T+1, and neuron k is processed at T+1+k with no stalls. Its spike is visible at T+2+k.
- With no stalls, DONE is entered at T+1+N and `done`=1 at T+1+N, provided `spike_valid` is clear. The earliest next `tick` is accepted at T+2+N.
- Each stall cycle delays all subsequent timing by one cycle.
- `vmem` writeback is visible on `dbg_vmem` the cycle after processing.
- `i_data` must be valid in the same cycle that `i_addr` presents the index.

## Test plan
- N=4, VTH=50, LEAK_SHIFT=3, REFRAC=2, neuron0 `i_data`=10 and others 0, `spike_ready`=1, 10 ticks:
  - neuron0 `vmem` after ticks 1-6 is 10,19,27,34,40,45.
  - Tick 7 gives `spike_id`=0 and `vmem`=0.
  - Ticks 8-9 hold `vmem`=0 (refractory); tick 10 gives `vmem`=10.
- Single tick with all currents 0 at T: `busy` is high T+1..T+5, `done` is 1 only at T+5, `cur_idx` steps 0,1,2,3, and there are no spikes.
- Neurons 1 and 2 preloaded near threshold with `spike_ready`=0 for 5 cycles after the first spike:
  - `spike_id`=1 is held stable.
  - `cur_idx` is frozen at 2 and neuron2 is not written until the handshake completes.
  - Then `spike_id`=2 follows and `done` is delayed by 5 cycles.
- `tick` asserted again in the cycle after sweep start: `overrun`=1 and remains set, and no extra sweep runs.
- `reset` asserted at sweep index 2: the next cycle has all outputs 0, FSM in IDLE, `dbg_vmem`=0 for all indices, and no `done` pulse.
- `i_data`=255 with VW=8 instance, VTH=255: `vmem` saturates at 255 and then spikes. There is no wrap to a small value.
